// File: rtl/coeff_token_ctrl_pkg.sv
// Shared types and constants for the CAVLC coeff_token controller (package ct_pkg).
// The optional statistics counters are enabled by defining COEFF_TOKEN_STATS_EN.
package ct_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BITS,
        LOOKUP,
        FLC,
        SHIFT,
        DONE,
        ERR
    } state_t;

    localparam logic [2:0] TBL_NC0  = 3'd0;
    localparam logic [2:0] TBL_NC2  = 3'd1;
    localparam logic [2:0] TBL_NC4  = 3'd2;
    localparam logic [2:0] TBL_FLC  = 3'd3;
    localparam logic [2:0] TBL_CDC1 = 3'd4;
    localparam logic [2:0] TBL_CDC2 = 3'd5;
    localparam logic [2:0] TBL_BAD  = 3'd7;

    // Longest legal prefix per table; the FLC and unused slots are never consulted.
    localparam logic [4:0] MAX_LZ [8] = '{5'd14, 5'd13, 5'd9, 5'd15, 5'd7, 5'd12, 5'd0, 5'd0};

    localparam int LUT_TBL_W = 3;
    localparam int LUT_LZ_W  = 4;
    localparam int LUT_SEL_W = LUT_TBL_W + LUT_LZ_W;

    localparam logic [4:0] FLC_LEN = 5'd6;

endpackage

// File: rtl/coeff_token_ctrl_if.sv
// Bitstream, LUT-bank, shifter and result signals of the coeff_token controller.
// master = controller side, slave = surrounding residual decoder / LUT / shifter.
interface coeff_token_ctrl_if #(
    parameter int WIN_W = 16,
    parameter int NC_W  = 6
);
    import ct_pkg::*;

    logic                        start;
    logic signed [NC_W-1:0]      nc;
    logic [WIN_W-1:0]            win;
    logic                        win_valid;
    logic [LUT_SEL_W-1:0]        lut_sel;
    logic [2:0]                  lut_bits;
    logic [4:0]                  lut_total_coeff;
    logic [1:0]                  lut_trailing_ones;
    logic [4:0]                  lut_num_shift;
    logic                        shift_req;
    logic [4:0]                  shift_amt;
    logic                        shift_ack;
    logic [4:0]                  total_coeff;
    logic [1:0]                  trailing_ones;
    logic                        done;
    logic                        error;
    logic                        busy;

    modport master (
        input  start, nc, win, win_valid,
        input  lut_total_coeff, lut_trailing_ones, lut_num_shift, shift_ack,
        output lut_sel, lut_bits, shift_req, shift_amt,
        output total_coeff, trailing_ones, done, error, busy
    );

    modport slave (
        output start, nc, win, win_valid,
        output lut_total_coeff, lut_trailing_ones, lut_num_shift, shift_ack,
        input  lut_sel, lut_bits, shift_req, shift_amt,
        input  total_coeff, trailing_ones, done, error, busy
    );

endinterface

// File: rtl/coeff_token_ctrl_lzc.sv
// 16-bit leading-zero counter; also returns the three bits after the first '1',
// left-aligned and zero-padded when the window runs out.
module ct_lzc (
    input  logic [15:0] win,
    output logic [4:0]  lz,
    output logic [2:0]  suffix
);

    always_comb begin
        lz = 5'd16;
        for (int i = 0; i < 16; i++) begin
            if (win[i]) lz = 5'(15 - i);
        end
        // Normalise the first '1' to bit 18 of the padded window; the next three bits follow it.
        suffix = 3'(({win, 3'b000} << lz) >> 15);
    end

endmodule

// File: rtl/coeff_token_ctrl.sv
// CAVLC coeff_token decode sequencer: table select, prefix count, LUT/FLC decode, shift handshake.
// Define COEFF_TOKEN_STATS_EN to add the saturating stat_tokens/stat_errors counters.
module coeff_token_ctrl
    import ct_pkg::*;
#(
    parameter int WIN_W = 16,
    parameter int NC_W  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef COEFF_TOKEN_STATS_EN
    output logic [15:0]        stat_tokens,
    output logic [15:0]        stat_errors,
`endif
    coeff_token_ctrl_if.master bus
);

    state_t     state;
    logic [2:0] tbl;
    logic [5:0] flc_code;
    logic [4:0] tc_q;
    logic [1:0] t1_q;
    logic [4:0] lz;
    logic [2:0] suffix;
    logic       flc_zero;
    logic [4:0] flc_tc;
    logic [1:0] flc_t1;
    logic       flc_bad;

    function automatic logic [2:0] table_of(input logic signed [NC_W-1:0] v);
        if (v >= NC_W'(8))       return TBL_FLC;
        else if (v >= NC_W'(4))  return TBL_NC4;
        else if (v >= NC_W'(2))  return TBL_NC2;
        else if (v >= NC_W'(0))  return TBL_NC0;
        else if (v == NC_W'(-1)) return TBL_CDC1;
        else if (v == NC_W'(-2)) return TBL_CDC2;
        else                     return TBL_BAD;
    endfunction

    ct_lzc u_lzc (
        .win    (bus.win[WIN_W-1 -: 16]),
        .lz     (lz),
        .suffix (suffix)
    );

    // 6-bit fixed-length code xxxxyy: TotalCoeff = xxxx+1, TrailingOnes = yy, 000011 means empty.
    assign flc_zero = (flc_code == 6'b000011);
    assign flc_tc   = flc_zero ? 5'd0 : {1'b0, flc_code[5:2]} + 5'd1;
    assign flc_t1   = flc_zero ? 2'd0 : flc_code[1:0];
    assign flc_bad  = ({3'b000, flc_t1} > flc_tc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            tbl               <= 3'd0;
            flc_code          <= 6'd0;
            tc_q              <= 5'd0;
            t1_q              <= 2'd0;
            bus.lut_sel       <= '0;
            bus.lut_bits      <= 3'd0;
            bus.shift_req     <= 1'b0;
            bus.shift_amt     <= 5'd0;
            bus.total_coeff   <= 5'd0;
            bus.trailing_ones <= 2'd0;
            bus.done          <= 1'b0;
            bus.error         <= 1'b0;
            bus.busy          <= 1'b0;
        end else begin
            bus.done  <= 1'b0;
            bus.error <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tbl      <= table_of(bus.nc);
                        bus.busy <= 1'b1;
                        state    <= WAIT_BITS;
                    end
                end
                WAIT_BITS: begin
                    if (tbl == TBL_BAD) begin
                        bus.done          <= 1'b1;
                        bus.error         <= 1'b1;
                        bus.total_coeff   <= 5'd0;
                        bus.trailing_ones <= 2'd0;
                        state             <= ERR;
                    end else if (bus.win_valid) begin
                        if (tbl == TBL_FLC) begin
                            flc_code <= bus.win[WIN_W-1 -: 6];
                            state    <= FLC;
                        end else if (lz > MAX_LZ[tbl]) begin
                            bus.done          <= 1'b1;
                            bus.error         <= 1'b1;
                            bus.total_coeff   <= 5'd0;
                            bus.trailing_ones <= 2'd0;
                            state             <= ERR;
                        end else begin
                            bus.lut_sel  <= {tbl, lz[LUT_LZ_W-1:0]};
                            bus.lut_bits <= suffix;
                            state        <= LOOKUP;
                        end
                    end
                end
                LOOKUP: begin
                    tc_q          <= bus.lut_total_coeff;
                    t1_q          <= bus.lut_trailing_ones;
                    bus.shift_amt <= bus.lut_num_shift;
                    bus.shift_req <= 1'b1;
                    state         <= SHIFT;
                end
                FLC: begin
                    if (flc_bad) begin
                        bus.done          <= 1'b1;
                        bus.error         <= 1'b1;
                        bus.total_coeff   <= 5'd0;
                        bus.trailing_ones <= 2'd0;
                        state             <= ERR;
                    end else begin
                        tc_q          <= flc_tc;
                        t1_q          <= flc_t1;
                        bus.shift_amt <= FLC_LEN;
                        bus.shift_req <= 1'b1;
                        state         <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Results move to the outputs only with Done so they stay stable between tokens.
                    if (bus.shift_ack) begin
                        bus.shift_req     <= 1'b0;
                        bus.total_coeff   <= tc_q;
                        bus.trailing_ones <= t1_q;
                        bus.done          <= 1'b1;
                        state             <= DONE;
                    end
                end
                DONE, ERR: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef COEFF_TOKEN_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_tokens <= 16'd0;
            stat_errors <= 16'd0;
        end else if (bus.done) begin
            stat_tokens <= sat_inc(stat_tokens);
            if (bus.error) stat_errors <= sat_inc(stat_errors);
        end
    end
`endif

endmodule
